// File: rtl/aoi211_pipe_pkg.sv
// Shared definitions for the pipelined AOI211/OAI211 lane datapath.
// The lane function here is used by the RTL and by the bench reference model.
package aoi211_pipe_pkg;

    localparam logic MODE_AOI   = 1'b0;
    localparam logic MODE_OAI   = 1'b1;
    localparam int   WIDTH_MAX  = 64;
    localparam int   STAGES_MAX = 4;

    function automatic logic aoi211_eval(input logic mode, input logic a1, input logic a2,
                                         input logic b, input logic c);
        if (mode == MODE_OAI) return ~((a1 | a2) & b & c);
        return ~((a1 & a2) | b | c);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_stage.sv
// One pipeline slot: valid/data/mode register that loads when empty or draining.
// Data only changes when a valid item arrives, so bubbles leave payload untouched.
module gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_stage
    import aoi211_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             mode
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             mode_q, mode_d;

    assign ready = ~valid_q | down_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                mode_d = in_mode;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= MODE_AOI;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign mode  = mode_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe.sv
// Multi-lane AOI211/OAI211 evaluated at the input, then carried through a
// STAGES-deep elastic register chain with valid/ready flow control.
module gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe
    import aoi211_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             MODE,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ZN,
    output logic             OUT_MODE
);

    logic [WIDTH-1:0]             eval_zn;
    logic [STAGES-1:0]            src_v, src_m, v, m;
    logic [STAGES-1:0][WIDTH-1:0] src_d, d;
    logic [STAGES:0]              adv;

    always_comb begin
        eval_zn = '0;
        for (int i = 0; i < WIDTH; i++)
            eval_zn[i] = aoi211_eval(MODE, A1[i], A2[i], B[i], C[i]);
    end

    // The ready chain runs combinationally from OUT_READY back to IN_READY so a
    // full pipeline can accept and release in the same cycle.
    assign adv[STAGES] = OUT_READY;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_v[k] = IN_VALID;
            assign src_d[k] = eval_zn;
            assign src_m[k] = MODE;
        end else begin : g_link
            assign src_v[k] = v[k-1];
            assign src_d[k] = d[k-1];
            assign src_m[k] = m[k-1];
        end

        gf180mcu_fd_sc_mcu9t5v0__aoi211_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK        (CLK),
            .RST        (RST),
            .in_valid   (src_v[k]),
            .in_data    (src_d[k]),
            .in_mode    (src_m[k]),
            .down_ready (adv[k+1]),
            .ready      (adv[k]),
            .valid      (v[k]),
            .data       (d[k]),
            .mode       (m[k])
        );
    end

    assign IN_READY  = adv[0];
    assign OUT_VALID = v[STAGES-1];
    assign ZN        = v[STAGES-1] ? d[STAGES-1] : '0;
    assign OUT_MODE  = m[STAGES-1];

endmodule
